// File: rtl/slot_frame_capture_pkg.sv
// Shared types and helpers for the slot frame capture block.
// Contents: FSM state enum sfc_state_t and slots_last() which returns the
// index of the final slot in a frame for a given voices/envelopes geometry.
package slot_frame_pkg;

   typedef enum logic {
      HUNT   = 1'b0,
      LOCKED = 1'b1
   } sfc_state_t;

   // Index of the last slot in a frame (slots are numbered 0..voices*envs-1).
   function automatic int slots_last(input int voices, input int envs);
      return voices * envs - 1;
   endfunction

endpackage

// File: rtl/slot_frame_capture_if.sv
// Bundle of the slot stream, host read port and status signals.
// Ports: stream in (xxxx, xxxx_zero, slot_data), control (err_clr),
// read port (rd_req, rd_addr -> rd_data, rd_ack), status (locked, seq_err,
// frame_ready, frame_cnt). master = stream/host side, slave = capture block.
interface slot_frame_capture_if #(
   parameter int IW        = 6,
   parameter int D_WIDTH   = 24,
   parameter int CNT_WIDTH = 16
);
   logic [IW-1:0]        xxxx;
   logic                 xxxx_zero;
   logic [D_WIDTH-1:0]   slot_data;
   logic                 err_clr;
   logic                 rd_req;
   logic [IW-1:0]        rd_addr;
   logic [D_WIDTH-1:0]   rd_data;
   logic                 rd_ack;
   logic                 locked;
   logic                 seq_err;
   logic                 frame_ready;
   logic [CNT_WIDTH-1:0] frame_cnt;

   modport master (
      output xxxx, xxxx_zero, slot_data, err_clr, rd_req, rd_addr,
      input  rd_data, rd_ack, locked, seq_err, frame_ready, frame_cnt
   );

   modport slave (
      input  xxxx, xxxx_zero, slot_data, err_clr, rd_req, rd_addr,
      output rd_data, rd_ack, locked, seq_err, frame_ready, frame_cnt
   );
endinterface

// File: rtl/slot_frame_capture_dpram.sv
// Simple dual-port RAM holding two frame banks (bank is the address MSB).
// Ports: clk/rst, write port (we, waddr, wdata), registered read port
// (re, raddr, rzero -> rdata); rzero forces the captured word to 0.
module slot_dpram #(
   parameter int AW = 6,
   parameter int DW = 24
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          we,
   input  logic [AW:0]   waddr,
   input  logic [DW-1:0] wdata,
   input  logic          re,
   input  logic [AW:0]   raddr,
   input  logic          rzero,
   output logic [DW-1:0] rdata
);

   localparam int DEPTH = 2 * (2 ** AW);

   // Storage is deliberately not reset.
   logic [DW-1:0] mem [0:DEPTH-1];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Read register holds its value between requests; reset gives a clean 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata <= '0;
      end else if (re) begin
         rdata <= rzero ? '0 : mem[raddr];
      end
   end

endmodule

// File: rtl/slot_frame_capture.sv
// Receive-side slot tracker: locks onto the slot index / frame marker stream,
// checks it is gap-free and captures one word per slot into a double-buffered
// frame store; completed frames are read via a 1-cycle request/ack port.
// Ports: sCLK_XVXENVS clock, reset_reg async active-high reset, bus (slave).
module slot_frame_capture
   import slot_frame_pkg::*;
#(
   parameter int VOICES    = 8,
   parameter int V_ENVS    = 8,
   parameter int V_WIDTH   = 3,
   parameter int E_WIDTH   = 3,
   parameter int D_WIDTH   = 24,
   parameter int CNT_WIDTH = 16
) (
   input  logic                  sCLK_XVXENVS,
   input  logic                  reset_reg,
   slot_frame_capture_if.slave   bus
);

   localparam int IW   = V_WIDTH + E_WIDTH;
   localparam int LAST = slots_last(VOICES, V_ENVS);
   localparam logic [IW-1:0] LAST_IDX = LAST[IW-1:0];

   sfc_state_t           state;
   logic [IW-1:0]        exp_idx;
   logic                 bank_sel;
   logic                 locked;
   logic                 seq_err;
   logic                 frame_ready;
   logic [CNT_WIDTH-1:0] frame_cnt;
   logic                 rd_ack;

   logic                 is_last;
   logic                 seq_fault;
   logic                 wr_en;
   logic                 rd_oob;
   logic [D_WIDTH-1:0]   ram_q;

   // Sample classification. The marker must coincide with LAST exactly, so a
   // marker on any other slot or a LAST without the marker are both faults.
   always_comb begin
      is_last   = (bus.xxxx == LAST_IDX);
      seq_fault = 1'b0;
      if (state == LOCKED) begin
         seq_fault = (bus.xxxx != exp_idx) || (bus.xxxx_zero != is_last);
      end
      wr_en  = (state == LOCKED) && !seq_fault;
      rd_oob = int'(bus.rd_addr) > LAST;
   end

   always_ff @(posedge sCLK_XVXENVS or posedge reset_reg) begin
      if (reset_reg) begin
         state       <= HUNT;
         exp_idx     <= '0;
         bank_sel    <= 1'b0;
         locked      <= 1'b0;
         seq_err     <= 1'b0;
         frame_ready <= 1'b0;
         frame_cnt   <= '0;
         rd_ack      <= 1'b0;
      end else begin
         frame_ready <= 1'b0;
         rd_ack      <= bus.rd_req;

         // A new fault beats a simultaneous clear.
         if (seq_fault) begin
            seq_err <= 1'b1;
         end else if (bus.err_clr) begin
            seq_err <= 1'b0;
         end

         case (state)
            HUNT: begin
               if (is_last && bus.xxxx_zero) begin
                  state   <= LOCKED;
                  exp_idx <= '0;
                  locked  <= 1'b1;
               end
            end
            LOCKED: begin
               if (seq_fault) begin
                  // Partial frame is abandoned: no swap, read bank untouched.
                  state  <= HUNT;
                  locked <= 1'b0;
               end else if (is_last) begin
                  // Frame end: the bank just filled becomes the read bank.
                  exp_idx     <= '0;
                  bank_sel    <= ~bank_sel;
                  frame_cnt   <= frame_cnt + 1'b1;
                  frame_ready <= 1'b1;
               end else begin
                  exp_idx <= exp_idx + 1'b1;
               end
            end
            default: begin
               state  <= HUNT;
               locked <= 1'b0;
            end
         endcase
      end
   end

   // Writes go to the bank not currently exposed to the host. Reads use the
   // pre-edge bank_sel, so a read coinciding with a swap sees the old frame.
   slot_dpram #(
      .AW (IW),
      .DW (D_WIDTH)
   ) u_ram (
      .clk   (sCLK_XVXENVS),
      .rst   (reset_reg),
      .we    (wr_en),
      .waddr ({~bank_sel, bus.xxxx}),
      .wdata (bus.slot_data),
      .re    (bus.rd_req),
      .raddr ({bank_sel, bus.rd_addr}),
      .rzero (rd_oob),
      .rdata (ram_q)
   );

   assign bus.rd_data     = ram_q;
   assign bus.rd_ack      = rd_ack;
   assign bus.locked      = locked;
   assign bus.seq_err     = seq_err;
   assign bus.frame_ready = frame_ready;
   assign bus.frame_cnt   = frame_cnt;

endmodule

// File: doc/slot_frame_capture.md
# slot_frame_capture

Receive-side counterpart of the voice/envelope slot timing generator. Tracks the incoming `xxxx` slot index and `xxxx_zero` frame marker, verifies that the sequence is gap-free, and captures one data word per slot into a double-buffered frame store. Completed frames are exposed to a host-side read port with a one-cycle request/acknowledge handshake.

## Interface
- `VOICES`, default 8: voices per frame.
- `V_ENVS`, default 8: envelopes per voice.
- `V_WIDTH`, default 3: voice field width.
- `E_WIDTH`, default 3: envelope field width.
- `D_WIDTH`, default 24: slot data width.
- `CNT_WIDTH`, default 16: frame counter width.
- Derived: SLOTS = VOICES*V_ENVS, which must be ≤ 2^(V_WIDTH+E_WIDTH); LAST = SLOTS-1; IW = V_WIDTH+E_WIDTH.
- `sCLK_XVXENVS` in 1: single clock; all logic on posedge.
- `reset_reg` in 1: asynchronous, active-high reset.
- `xxxx` in IW: incoming slot index.
- `xxxx_zero` in 1: frame-end marker, sampled together with `xxxx`.
- `slot_data` in D_WIDTH: data for the current slot.
- `err_clr` in 1: clears `seq_err`.
- `rd_req` in 1: read request, one-cycle pulse or held.
- `rd_addr` in IW: slot to read from the completed frame.
- `rd_data` out D_WIDTH: read data.
- `rd_ack` out 1: `rd_data` valid.
- `locked` out 1: sequence tracking is locked.
- `seq_err` out 1: sticky sequence error.
- `frame_ready` out 1: one-cycle pulse when a new frame is published.
- `frame_cnt` out CNT_WIDTH: number of published frames; wraps.

## Operation
- FSM states: HUNT and LOCKED.
- HUNT:
  - Nothing is written.
  - A sample with `xxxx`==LAST and `xxxx_zero`=1 moves the FSM to LOCKED, sets expected index exp=0, and sets `locked`=1.
- LOCKED, each cycle:
  - If `xxxx`≠exp → error.
  - If `xxxx_zero`=1 and `xxxx`≠LAST → error.
  - If `xxxx`==LAST and `xxxx_zero`=0 → error.
  - Otherwise write `slot_data` to the write bank at address `xxxx`, then advance exp by one, returning to 0 after LAST.
- Error:
  - Set `seq_err`, clear `locked`, return to HUNT.
  - Discard the partial frame: no swap; the read bank is untouched; the offending slot is not written.
- Frame end (LOCKED, `xxxx`==LAST, `xxxx_zero`=1):
  - Write slot LAST.
  - Toggle `bank_sel` (the read bank becomes the just-filled bank).
  - Increment `frame_cnt`.
  - Assert `frame_ready` for the next cycle.
- `err_clr` together with a new error: the set wins, so `seq_err` stays 1.
- Read port:
  - `rd_req` is sampled at posedge, using the read bank selected at that edge.
  - `rd_data` and `rd_ack` are registered one cycle later.
  - Back-to-back requests yield back-to-back acks.
  - `rd_addr` > LAST returns 0 with `rd_ack`=1.
- Memory is not reset. Reads before the first `frame_ready` return undefined data; the host gates reads on `frame_cnt`≠0.

## Timing
- Reset values: state HUNT, `bank_sel`=0, `locked`=0, `seq_err`=0, `frame_ready`=0, `frame_cnt`=0, `rd_ack`=0, `rd_data`=0.
- Reset mid-frame aborts the frame; the first frame after reset publishes only after a full lock plus SLOTS slots.
- Write latency: `slot_data` is captured at the same edge that samples `xxxx`.
- Lock latency: the LAST+zero sample locks at edge N; edge N+1 must sample `xxxx`=0.
- Swap: `bank_sel` toggles at the frame-end edge. A `rd_req` sampled at the next edge already reads the new frame. `frame_ready` is high exactly during that next cycle.
- Read latency: 1 cycle from `rd_req` sampled to `rd_ack`/`rd_data`.
- Simultaneous swap and `rd_req` at the same edge: the read uses the old bank.
- Error detection: `seq_err` and `locked`=0 are visible the cycle after the bad sample.

## Structure
- Package `slot_frame_pkg` holds:
  - the state enum `sfc_state_t` {HUNT, LOCKED};
  - function `slots_last(voices, envs)`.
- Sub-module `slot_dpram`: simple dual-port RAM, depth 2*2^IW, 1 write port and 1 registered read port, with `bank_sel` as the address MSB.
- Top-level contents: FSM, expected-index counter, error/sticky logic, frame counter, read handshake.

## Test plan
- Clean stream: reset, then index 0..63 repeated with zero at 63 and `slot_data`=0x100+index. Required: lock at the first 63, `frame_ready` after the next 63, `frame_cnt`=1, reading slot 5 gives 0x000105 with `rd_ack` one cycle after `rd_req`.
- Skipped index: during the second frame, send index 20 where 19 is expected. Required: `seq_err`=1, `locked`=0, `frame_cnt` unchanged, frame-1 data still readable; relock at the next 63.
- Misplaced zero: `xxxx_zero`=1 at index 30. Required: error; no swap; `frame_ready` stays 0.
- Read at swap: `rd_req` at the frame-end edge then at the following edge. Required: first ack returns the old frame, second returns the new frame.
- `err_clr` and a new error in the same cycle: `seq_err` stays 1. `err_clr` alone clears it to 0 the next cycle.
- Reset mid-frame at index 40: all outputs return to reset values, `frame_cnt`=0; after relock the first frame publishes correctly.
